// File: rtl/pwm_fade_ctrl.sv
// Duty-cycle fader feeding a downstream pwm: ramps duty_cycle one LSB per step toward a loaded target,
// and generates the pwm enable tick. Optional triangle "breathe" mode is enabled by PWM_FADE_BREATHE_EN.
module pwm_fade_ctrl #(
    parameter int CTRVAL  = 256,
    parameter int CTRLEN  = $clog2(CTRVAL),
    parameter int PRESC_W = 16,
    parameter int PWM_DIV = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [CTRLEN-1:0] target,
    input  logic [PRESC_W-1:0] step_div,
    input  logic              breathe,
    output logic [CTRLEN-1:0] duty_cycle,
    output logic              pwm_tick,
    output logic              busy,
    output logic              done,
    output logic [1:0]        state_dbg
);

    typedef enum logic [1:0] {IDLE = 2'd0, UP = 2'd1, DOWN = 2'd2} state_t;

    localparam int TICK_W = (PWM_DIV > 0) ? $clog2(PWM_DIV + 1) : 1;
    localparam logic [CTRLEN-1:0] DUTY_MAX = CTRLEN'(CTRVAL - 1);
    localparam logic [TICK_W-1:0] TICK_MAX = TICK_W'(PWM_DIV);

    state_t             state, state_n;
    logic [CTRLEN-1:0]  duty_n, target_q, target_n, tgt_clamp, up_next, dn_next;
    logic [PRESC_W-1:0] div_q, div_n, step_ctr, ctr_n;
    logic [TICK_W-1:0]  tick_ctr;
    logic               done_n, step_now, breathe_on;

`ifdef PWM_FADE_BREATHE_EN
    assign breathe_on = breathe;
`else
    logic unused_breathe;
    assign unused_breathe = breathe;
    assign breathe_on     = 1'b0;
`endif

    // Compare one bit wider so the clamp stays meaningful when CTRVAL is not a power of two.
    assign tgt_clamp = ({1'b0, target} > {1'b0, DUTY_MAX}) ? DUTY_MAX : target;
    assign step_now  = (step_ctr == div_q);
    assign up_next   = duty_cycle + 1'b1;
    assign dn_next   = duty_cycle - 1'b1;
    assign state_dbg = state;

    always_comb begin
        state_n  = state;
        duty_n   = duty_cycle;
        target_n = target_q;
        div_n    = div_q;
        ctr_n    = step_ctr;
        done_n   = 1'b0;
        if (load) begin
            // A retarget discards any step that would have landed this cycle.
            target_n = tgt_clamp;
            div_n    = step_div;
            ctr_n    = '0;
            if (tgt_clamp > duty_cycle)      state_n = UP;
            else if (tgt_clamp < duty_cycle) state_n = DOWN;
            else begin
                state_n = IDLE;
                done_n  = 1'b1;
            end
        end else begin
            case (state)
                UP: begin
                    if (!step_now) begin
                        ctr_n = step_ctr + 1'b1;
                    end else begin
                        ctr_n = '0;
                        if (duty_cycle == DUTY_MAX) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            duty_n = up_next;
                            if (up_next == target_q || up_next == DUTY_MAX) begin
                                if (breathe_on) state_n = DOWN;
                                else begin
                                    state_n = IDLE;
                                    done_n  = 1'b1;
                                end
                            end
                        end
                    end
                end
                DOWN: begin
                    if (!step_now) begin
                        ctr_n = step_ctr + 1'b1;
                    end else begin
                        ctr_n = '0;
                        if (duty_cycle == '0) begin
                            state_n = IDLE;
                            done_n  = 1'b1;
                        end else begin
                            duty_n = dn_next;
                            // A breathing down-leg runs to 0; a plain one stops at target (or 0 after a breathe leg).
                            if (breathe_on) begin
                                if (dn_next == '0) state_n = UP;
                            end else if (dn_next == target_q || dn_next == '0) begin
                                state_n = IDLE;
                                done_n  = 1'b1;
                            end
                        end
                    end
                end
                default: ctr_n = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            duty_cycle <= '0;
            target_q   <= '0;
            div_q      <= '0;
            step_ctr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            state      <= state_n;
            duty_cycle <= duty_n;
            target_q   <= target_n;
            div_q      <= div_n;
            step_ctr   <= ctr_n;
            busy       <= (state_n != IDLE);
            done       <= done_n;
        end
    end

    // Free-running divider for the downstream pwm counter enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_ctr <= '0;
            pwm_tick <= 1'b0;
        end else begin
            tick_ctr <= (tick_ctr == TICK_MAX) ? '0 : tick_ctr + 1'b1;
            pwm_tick <= (tick_ctr == TICK_MAX);
        end
    end

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Directed bench for pwm_fade_ctrl with default parameters; breathe checks follow PWM_FADE_BREATHE_EN.
module tb_pwm_fade_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        load;
    logic [7:0]  target;
    logic [15:0] step_div;
    logic        breathe;
    logic [7:0]  duty_cycle;
    logic        pwm_tick;
    logic        busy;
    logic        done;
    logic [1:0]  state_dbg;

    int n_checks = 0;
    int n_bad    = 0;
    logic [31:0] exp_q[$];

    pwm_fade_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .load       (load),
        .target     (target),
        .step_div   (step_div),
        .breathe    (breathe),
        .duty_cycle (duty_cycle),
        .pwm_tick   (pwm_tick),
        .busy       (busy),
        .done       (done),
        .state_dbg  (state_dbg)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    // driver tasks
    task automatic step_clk();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic load_tgt(input logic [7:0] t, input logic [15:0] d);
        target   = t;
        step_div = d;
        load     = 1'b1;
        step_clk();
        load     = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int max_cycles);
        int n = 0;
        while (!done && n < max_cycles) begin
            step_clk();
            n++;
        end
        check({tag, "_reached"}, done, 1);
    endtask

    initial begin
        rst = 1'b1; load = 1'b0; target = '0; step_div = '0; breathe = 1'b0;
        step_clk();
        step_clk();
        check("rst_duty", duty_cycle, 0);
        check("rst_tick", pwm_tick, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        rst = 1'b0;
        step_clk();
        check("tick_div0", pwm_tick, 1);

        // 1: 0 -> 10, step every 4 clocks, done at cycle 40
        load_tgt(8'd10, 16'd3);
        check("t1_busy0", busy, 1);
        check("t1_duty0", duty_cycle, 0);
        for (int k = 1; k <= 41; k++) begin
            step_clk();
            check($sformatf("t1_duty_c%0d", k), duty_cycle, (k >= 40) ? 10 : k / 4);
            check($sformatf("t1_done_c%0d", k), done, (k == 40) ? 1 : 0);
            if (k == 39 || k == 40) check($sformatf("t1_busy_c%0d", k), busy, (k == 39) ? 1 : 0);
        end

        // 2: 200 -> 50 at one step per clock
        load_tgt(8'd200, 16'd0);
        wait_done("t2_up", 300);
        check("t2_at200", duty_cycle, 200);
        load_tgt(8'd50, 16'd0);
        check("t2_busy_l", busy, 1);
        for (int k = 1; k <= 150; k++) begin
            step_clk();
            if (k == 1)   check("t2_duty_1", duty_cycle, 199);
            if (k == 149) check("t2_busy_149", busy, 1);
            if (k == 149) check("t2_done_149", done, 0);
        end
        check("t2_duty_end", duty_cycle, 50);
        check("t2_done_end", done, 1);
        check("t2_busy_end", busy, 0);

        // 3: reverse while a step is pending at duty 100
        load_tgt(8'd100, 16'd0);
        wait_done("t3_pre", 100);
        load_tgt(8'd180, 16'd1);
        check("t3_busy_up", busy, 1);
        check("t3_duty_hold0", duty_cycle, 100);
        load_tgt(8'd90, 16'd1);
        check("t3_step_dropped", duty_cycle, 100);
        begin
            logic [7:0] max_duty = duty_cycle;
            for (int k = 1; k <= 20; k++) begin
                step_clk();
                if (duty_cycle > max_duty) max_duty = duty_cycle;
                if (k == 2)  check("t3_duty_2", duty_cycle, 99);
                if (k == 19) check("t3_done_19", done, 0);
            end
            check("t3_no_overshoot", max_duty, 100);
        end
        check("t3_duty_end", duty_cycle, 90);
        check("t3_done_end", done, 1);

        // 4: load target equal to duty
        load_tgt(8'd37, 16'd0);
        wait_done("t4_pre", 100);
        step_clk();
        load_tgt(8'd37, 16'd5);
        check("t4_done", done, 1);
        check("t4_busy", busy, 0);
        check("t4_duty", duty_cycle, 37);
        step_clk();
        check("t4_done_clr", done, 0);
        check("t4_duty_hold", duty_cycle, 37);

        // 5: reset mid-ramp, then restart from 0
        load_tgt(8'd200, 16'd0);
        for (int k = 1; k <= 83; k++) step_clk();
        check("t5_duty_120", duty_cycle, 120);
        rst = 1'b1;
        load = 1'b1; target = 8'd250;
        step_clk();
        rst = 1'b0; load = 1'b0;
        check("t5_rst_duty", duty_cycle, 0);
        check("t5_rst_busy", busy, 0);
        check("t5_rst_tick", pwm_tick, 0);
        load_tgt(8'd3, 16'd0);
        for (int k = 1; k <= 3; k++) step_clk();
        check("t5_restart_duty", duty_cycle, 3);
        check("t5_restart_done", done, 1);

        // load on the arrival edge: load wins, no done pulse
        load_tgt(8'd6, 16'd0);
        step_clk();
        step_clk();
        check("arr_duty5", duty_cycle, 5);
        load_tgt(8'd2, 16'd0);
        check("arr_no_done", done, 0);
        check("arr_hold", duty_cycle, 5);
        check("arr_busy", busy, 1);
        for (int k = 1; k <= 3; k++) step_clk();
        check("arr_down_duty", duty_cycle, 2);
        check("arr_down_done", done, 1);

        // 6: breathe
        load_tgt(8'd0, 16'd0);
        wait_done("t6_pre", 10);
        check("t6_at0", duty_cycle, 0);
        breathe = 1'b1;
        load_tgt(8'd4, 16'd0);
`ifdef PWM_FADE_BREATHE_EN
        foreach (exp_q[i]) exp_q.delete(i);
        exp_q = '{1, 2, 3, 4, 3, 2, 1, 0, 1, 2};
        for (int k = 1; k <= 10; k++) begin
            logic [31:0] e;
            step_clk();
            e = exp_q.pop_front();
            check($sformatf("t6_duty_c%0d", k), duty_cycle, e);
            check($sformatf("t6_nodone_c%0d", k), done, 0);
        end
        breathe = 1'b0;
        step_clk();
        check("t6_leg_duty3", duty_cycle, 3);
        step_clk();
        check("t6_stop_duty", duty_cycle, 4);
        check("t6_stop_done", done, 1);
        check("t6_stop_busy", busy, 0);
`else
        for (int k = 1; k <= 5; k++) begin
            step_clk();
            check($sformatf("t6_oneshot_c%0d", k), duty_cycle, (k >= 4) ? 4 : k);
            if (k == 4) check("t6_oneshot_done", done, 1);
        end
        check("t6_oneshot_busy", busy, 0);
`endif
        breathe = 1'b0;

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
